// File: rtl/fadd_pkg.sv
// Field layout, FSM state type and helpers shared by the fadd_sched block.
package fadd_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_W   = 23;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // +0 and -0 only; a zero exponent with a nonzero fraction is not a zero here.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[EXP_MSB:EXP_LSB] == '0) && (v[FRAC_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/fadd_sched_if.sv
// Request/result bundle between the requesters/consumer and the fadd_sched scheduler.
interface fadd_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_x;
    logic [IDW-1:0]       res_id;
    logic                 res_err;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_x, res_id, res_err
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_x, res_id, res_err
    );
endinterface

// File: rtl/fadd_core.sv
// Combinational align/add/normalize for same-sign singles; expects exp(i_a) >= exp(i_b), truncating.
module fadd_core
    import fadd_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_x,
    output logic        o_err
);
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [7:0]        w_d;
    logic [7:0]        w_ex;
    logic [24:0]       w_mb;
    logic [24:0]       w_sum;
    logic [FRAC_W-1:0] w_fx;

    assign w_ea  = i_a[EXP_MSB:EXP_LSB];
    assign w_eb  = i_b[EXP_MSB:EXP_LSB];
    assign w_d   = w_ea - w_eb;
    assign w_mb  = {2'b01, i_b[FRAC_W-1:0]} >> w_d;
    assign w_sum = {2'b01, i_a[FRAC_W-1:0]} + w_mb;
    // A carry out renormalises by one place; exponent wraps on overflow.
    assign w_ex  = w_ea + {7'd0, w_sum[24]};
    assign w_fx  = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

    assign o_x   = {i_a[SIGN_BIT], w_ex, w_fx};
    assign o_err = i_a[SIGN_BIT] ^ i_b[SIGN_BIT];
endmodule

// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one fadd_core among NREQ requesters.
// Optional FADD_ZERO_BYPASS_EN: +/-0 operands bypass the adder and pass the other operand through.
module fadd_sched
    import fadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic         clk,
    input  logic         rst,
    fadd_sched_if.slave  bus
);
    localparam int unsigned N = NREQ;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic            r_res_valid;
    logic [31:0]     r_res_x;
    logic [IDW-1:0]  r_res_id;
    logic            r_res_err;

    logic            w_any;
    logic [IDW-1:0]  w_grant;
    logic [NREQ-1:0] w_req_ready;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [31:0]     w_core_x;
    logic            w_core_err;
    logic [31:0]     w_x;
    logic            w_err;

    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(r_rr_ptr) + k) % N;
            if (!w_any && bus.req_valid[IDW'(idx)]) begin
                w_any   = 1'b1;
                w_grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == IDLE && w_any && !rst) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_a = bus.req_a[32*w_grant +: 32];
    assign w_b = bus.req_b[32*w_grant +: 32];

    fadd_core u_core (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_x   (w_core_x),
        .o_err (w_core_err)
    );

`ifdef FADD_ZERO_BYPASS_EN
    always_comb begin
        w_x   = w_core_x;
        w_err = w_core_err;
        if (is_zero(r_op_b)) begin
            w_x   = r_op_a;
            w_err = 1'b0;
        end else if (is_zero(r_op_a)) begin
            w_x   = r_op_b;
            w_err = 1'b0;
        end
    end
`else
    assign w_x   = w_core_x;
    assign w_err = w_core_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res_valid <= 1'b0;
            r_res_x     <= '0;
            r_res_id    <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        if (w_b[EXP_MSB:EXP_LSB] > w_a[EXP_MSB:EXP_LSB]) begin
                            r_op_a <= w_b;
                            r_op_b <= w_a;
                        end else begin
                            r_op_a <= w_a;
                            r_op_b <= w_b;
                        end
                        r_id     <= w_grant;
                        r_rr_ptr <= w_grant;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_res_x     <= w_x;
                    r_res_id    <= r_id;
                    r_res_err   <= w_err;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_x     = r_res_x;
    assign bus.res_id    = r_res_id;
    assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: transaction-level reference model checked every cycle, plus directed literal cases.
module tb_fadd_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fadd_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fadd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference sum: larger exponent first, integer mantissas, truncate on align and renormalise.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] x, output logic err);
        logic [31:0]     hi, lo;
        longint unsigned mh, ml, s;
        int              e, sh;
        if (b[30:23] > a[30:23]) begin hi = b; lo = a; end
        else                     begin hi = a; lo = b; end
        sh = int'(hi[30:23]) - int'(lo[30:23]);
        mh = 64'(hi[22:0]) + 64'h80_0000;
        ml = (64'(lo[22:0]) + 64'h80_0000) >> sh;
        s  = mh + ml;
        e  = int'(hi[30:23]);
        if (s >= 64'h100_0000) begin s = s >> 1; e = e + 1; end
        x   = {hi[31], 8'(e), 23'(s)};
        err = (hi[31] != lo[31]);
`ifdef FADD_ZERO_BYPASS_EN
        if (lo[30:0] == 31'd0) begin x = hi; err = 1'b0; end
        else if (hi[30:0] == 31'd0) begin x = lo; err = 1'b0; end
`endif
    endfunction

    // Model: one operation outstanding at most; grants only when nothing is outstanding.
    logic           m_out = 1'b0;
    int             m_age = 0;
    int             m_last = NREQ - 1;
    logic [31:0]    m_pend_x, m_show_x;
    logic [IDW-1:0] m_pend_id, m_show_id;
    logic           m_pend_err, m_show_err;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic            exp_vld;
        int              g, idx;
        if (rst) begin
            m_out      = 1'b0;
            m_age      = 0;
            m_last     = NREQ - 1;
            m_show_x   = '0;
            m_show_id  = '0;
            m_show_err = 1'b0;
        end else begin
            if (m_out) m_age++;
            g = -1;
            if (!m_out) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (g < 0 && bus.req_valid[IDW'(idx)]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            exp_vld = m_out && (m_age >= 2);
            if (m_out && m_age == 2) begin
                m_show_x   = m_pend_x;
                m_show_id  = m_pend_id;
                m_show_err = m_pend_err;
            end
            chk("m_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("m_res_valid", 32'(bus.res_valid), 32'(exp_vld));
            chk("m_res_x",     bus.res_x,          m_show_x);
            chk("m_res_id",    32'(bus.res_id),    32'(m_show_id));
            chk("m_res_err",   32'(bus.res_err),   32'(m_show_err));
            if (g >= 0) begin
                m_out     = 1'b1;
                m_age     = 0;
                m_last    = g;
                m_pend_id = IDW'(g);
                ref_add(32'(bus.req_a >> (32 * g)), 32'(bus.req_b >> (32 * g)), m_pend_x, m_pend_err);
            end
            if (exp_vld && bus.res_ready) m_out = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request from idle with res_ready=1: grant at T, result at T+2, back to IDLE at T+3.
    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] x, input logic err, input string nm);
        bus.req_valid = NREQ'(1) << idx;
        bus.req_a     = (32*NREQ)'(a) << (32 * idx);
        bus.req_b     = (32*NREQ)'(b) << (32 * idx);
        @(negedge clk);
        chk({nm, "_grant"}, 32'(bus.req_ready), 32'(NREQ'(1) << idx));
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk({nm, "_calc_valid"}, 32'(bus.res_valid), 32'd0);
        step();
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({nm, "_x"},     bus.res_x,          x);
        chk({nm, "_id"},    32'(bus.res_id),    32'(idx));
        chk({nm, "_err"},   32'(bus.res_err),   32'(err));
        step();
    endtask

    function automatic logic [63:0] rnd_pair();
        logic [7:0]  ea, eb;
        logic        sa, sb;
        logic [31:0] a, b;
        int unsigned m;
        m  = $urandom_range(0, 7);
        ea = 8'($urandom_range(1, 254));
        sa = 1'($urandom_range(0, 1));
        sb = (m == 7) ? ~sa : sa;
        case (m)
            0:       eb = ea;
            1:       eb = ea - 8'($urandom_range(24, 30));
            2:       eb = 8'($urandom_range(1, 254));
            default: eb = ea - 8'($urandom_range(0, 4));
        endcase
        a = {sa, ea, 23'($urandom)};
        b = {sb, eb, 23'($urandom)};
`ifdef FADD_ZERO_BYPASS_EN
        if (m == 6) b = 32'h0;
`endif
        return {a, b};
    endfunction

    initial begin
        logic [63:0]        p;
        logic [32*NREQ-1:0] va, vb;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_x",     bus.res_x,          32'd0);
        chk("rst_res_id",    32'(bus.res_id),    32'd0);
        chk("rst_res_err",   32'(bus.res_err),   32'd0);
        step();

        run_one(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "single");
        run_one(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, "swap");
        run_one(1, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b1, "signmix");
        run_one(3, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0, "gap24");

        // Round robin with every requester asserting: 0,1,2,3,0 at 3-cycle spacing.
        bus.req_valid = '1;
        bus.req_a     = {NREQ{32'h3F80_0000}};
        bus.req_b     = {NREQ{32'h4000_0000}};
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(bus.req_ready), (c % 3 == 0) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
            step();
        end
        bus.req_valid = '0;
        repeat (3) step();

        // Backpressure: result held while res_ready=0, other requesters kept waiting.
        bus.req_valid = 4'b0010;
        bus.req_a     = (32*NREQ)'(32'h3F80_0000) << 32;
        bus.req_b     = (32*NREQ)'(32'h4000_0000) << 32;
        @(negedge clk);
        chk("bp_grant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        step();
        bus.req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_x",     bus.res_x,          32'h4040_0000);
            chk("bp_id",    32'(bus.res_id),    32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_last", 32'(bus.res_valid), 32'd1);
        step();
        @(negedge clk);
        chk("bp_regrant", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        repeat (3) step();

        // Reset while CALC: that operation vanishes and requester 0 regains priority.
        bus.req_valid = 4'b0100;
        bus.req_a     = {32'h0, 32'h3F80_0000, 32'h0, 32'h4000_0000};
        bus.req_b     = {32'h0, 32'h3F80_0000, 32'h0, 32'h4000_0000};
        @(negedge clk);
        chk("rst_calc_grant", 32'(bus.req_ready), 32'h4);
        step();
        rst           = 1'b1;
        bus.req_valid = '1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_calc_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_calc_first", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rst_calc_valid2", 32'(bus.res_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rst_after_valid", 32'(bus.res_valid), 32'd1);
        chk("rst_after_id",    32'(bus.res_id),    32'd0);
        chk("rst_after_x",     bus.res_x,          32'h4080_0000);
        step();

`ifdef FADD_ZERO_BYPASS_EN
        run_one(1, 32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB, 1'b0, "zero_byp");
`endif

        for (int c = 0; c < 400; c++) begin
            va = '0;
            vb = '0;
            for (int r = 0; r < NREQ; r++) begin
                p  = rnd_pair();
                va = {p[63:32], va[32*NREQ-1:32]};
                vb = {p[31:0],  vb[32*NREQ-1:32]};
            end
            bus.req_valid = NREQ'($urandom_range(0, 15));
            bus.req_a     = va;
            bus.req_b     = vb;
            bus.res_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fadd_sched.md
Name: fadd_sched

Overview:
- Round-robin scheduler that shares one single-precision float-add datapath (fadd_core) among NREQ requesters.
- Uses valid/ready on both the request and result sides.
- Orders operands so that exponent(opA) >= exponent(opB), which fadd_core requires.
- Registers operands and result, so fadd_core is the only logic between the two register stages.

Parameters:
- NREQ, 4: number of requesters; supported range 2..8.
- IDW, 2: width of the requester index; must equal $clog2(NREQ).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant; one-hot or zero.
- req_a  input  32*NREQ  operand A, IEEE-754 single; requester i occupies bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, same packing as req_a.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_x  output  32  sum.
- res_id  output  IDW  index of the requester that owns the result.
- res_err  output  1  operand signs differed; the sum is not meaningful.

Behaviour:
- Reset values: state=IDLE, req_ready=0, res_valid=0, res_x=0, res_id=0, res_err=0, rr_ptr=NREQ-1 (requester 0 wins first).
- Synchronous rst overrides every state, including CALC and DONE. An in-flight operation is discarded and never presented on the result side.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally in this cycle only. Grant is qualified by state==IDLE.
  - The transfer completes in this cycle.
  - Registered at the clock edge: opA/opB (swapped if exp(b) > exp(a)), id=grant, rr_ptr=grant. Next state is CALC.
  - If no req_valid is set, stay in IDLE.
- CALC:
  - fadd_core evaluates the registered operands.
  - Registered at the clock edge: res_x, res_id and res_err (opA.sign != opB.sign). res_valid goes to 1 and next state is DONE.
- DONE:
  - res_valid=1; res_x, res_id and res_err are held stable.
  - When res_ready=1, the handshake completes: res_valid goes to 0 and next state is IDLE.
  - req_ready stays 0 throughout DONE (backpressure).
- Timing: grant at cycle T gives res_valid at T+2. Throughput is at most one operation per 3 cycles.
- fadd_core arithmetic, for same-sign operands with ea >= eb:
  - d = ea - eb (8 bits).
  - mb = {0,1,fb} >> d.
  - {c,h,s} = {0,1,fa} + mb.
  - ex = ea + c.
  - fx = c ? {h,s[22:1]} : s.
  - sign = sa.
  - Rounding is by truncation only.
- Boundaries:
  - Equal exponents: no swap.
  - d >= 25: B contributes nothing and the result equals opA.
  - Exponent overflow wraps. There is no Inf/NaN/denormal handling; this is a documented limitation.
- Sign mismatch: the result is computed as above with sign = opA sign, and res_err=1.

Optional Feature:
- Macro: FADD_ZERO_BYPASS_EN.
- Defined: in CALC, an operand with exponent==0 and fraction==0 (±0) is treated as zero.
  - res_x is the other operand, unchanged.
  - If both operands are zero, res_x = opA.
  - res_err=0 in either case.
  - Latency is unchanged.
- Undefined: zeros go through fadd_core as normal values with the implicit 1. For example, 0x00000000 + 0x3F800000 produces an incorrect sum.

Decomposition:
- Package fadd_pkg holds:
  - Field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, FRAC_W=23.
  - The state enum {IDLE, CALC, DONE}.
  - A helper function is_zero().
- One sub-module, fadd_core: the purely combinational align/add/normalize datapath. It is instantiated once inside fadd_sched.

Test Plan:
- Single request: requester 0, a=0x3F800000, b=0x3F800000 → req_ready[0] at T, res_valid at T+2, res_x=0x40000000, res_id=0, res_err=0.
- Swap: requester 2, a=0x3F800000 (1.0), b=0x40000000 (2.0) → res_x=0x40400000, res_id=2.
- Round-robin: all four req_valid held high, res_ready=1 → grant order 0,1,2,3,0, with grants 3 cycles apart.
- Backpressure: res_ready=0 for 5 cycles in DONE → res_valid, res_x and res_id are stable and req_ready=0. res_ready=1 → IDLE on the next cycle, new grant in that IDLE cycle.
- Sign mismatch and large gap:
  - a=0x3F800000, b=0xBF800000 → res_err=1.
  - a=0x4B800000, b=0x3F800000 (d=24) → res_x=0x4B800000 (B truncated away), res_err=0.
- Reset: rst pulsed during CALC → next cycle state=IDLE, res_valid=0; that result is never delivered; after release, requester 0 has priority. With FADD_ZERO_BYPASS_EN: a=0, b=0x40490FDB → res_x=0x40490FDB.
